// File: rtl/tap_stream_tx_pkg.sv
// Shared types for the tap stream transmitter: the float_24_8 word and FSM states.
package tap_stream_tx_pkg;

  typedef logic [31:0] float_24_8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STREAM   = 2'd1,
    WAIT_FIN = 2'd2
  } tap_tx_state_t;

endpackage

// File: rtl/tap_tx_skid_fifo.sv
// Two-entry skid FIFO holding tap words plus a first-word sideband bit.
module tap_tx_skid_fifo
  import tap_stream_tx_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  float_24_8  push_data,
  input  logic       push_fst,
  input  logic       pop,
  output logic [1:0] count,
  output float_24_8  head_data,
  output logic       head_fst
);

  float_24_8  data_q [2];
  logic [1:0] fst_q;
  logic       wr_ptr;
  logic       rd_ptr;

  // Storage, pointers and occupancy; push and pop may occur in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      fst_q     <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= push_data;
        fst_q[wr_ptr]  <= push_fst;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = data_q[rd_ptr];
  assign head_fst  = fst_q[rd_ptr];

endmodule

// File: rtl/tap_stream_tx.sv
// Streams NUM_TAPS coefficients from a synchronous tap store to a stage's tap input,
// then waits for the stage's load_finish (or a timeout) before returning to idle.
module tap_stream_tx
  import tap_stream_tx_pkg::*;
#(
  parameter int NUM_TAPS    = 144,
  parameter int AW          = 8,
  parameter int FIN_TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  float_24_8     mem_rd_data,
  output float_24_8     tap_in,
  output logic          tap_in_fst,
  output logic          tap_in_vld,
  input  logic          tap_in_rdy,
  input  logic          load_finish,
  output logic          busy,
  output logic          done,
  output logic          timeout
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(FIN_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST     = CW'(NUM_TAPS);
  localparam logic [CW-1:0] LAST_M1  = CW'(NUM_TAPS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FIN_TIMEOUT - 1);

  tap_tx_state_t state, next_state;
  logic [CW-1:0] issued, sent;
  logic [TW-1:0] timer;
  logic          inflight, inflight_fst;
  logic [1:0]    fifo_count;
  float_24_8     fifo_head;
  logic          fifo_head_fst, fifo_empty, fifo_push, fifo_pop, accept;
  logic          done_d, timeout_d;

  // Reads are throttled so FIFO occupancy plus the read in flight never exceeds two.
  assign mem_rd_en   = (state == STREAM) && (issued < LAST) &&
                       ((fifo_count + {1'b0, inflight}) < 2'd2);
  assign mem_rd_addr = issued[AW-1:0];

  // An empty FIFO passes the returning memory word straight through; if it is not
  // accepted that cycle it is captured so the presented word stays stable.
  assign fifo_empty = (fifo_count == 2'd0);
  assign tap_in_vld = !fifo_empty || inflight;
  assign tap_in     = !fifo_empty ? fifo_head : (inflight ? mem_rd_data : '0);
  assign tap_in_fst = !fifo_empty ? fifo_head_fst : inflight_fst;
  assign accept     = tap_in_vld && tap_in_rdy;
  assign fifo_pop   = accept && !fifo_empty;
  assign fifo_push  = inflight && !(fifo_empty && accept);
  assign busy       = (state != IDLE);

  tap_tx_skid_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (mem_rd_data),
    .push_fst  (inflight_fst),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head_data (fifo_head),
    .head_fst  (fifo_head_fst)
  );

  // FSM state register and registered completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= next_state;
      done    <= done_d;
      timeout <= timeout_d;
    end
  end

  // Next-state and pulse decode; start is refused in the cycle a pulse is showing.
  always_comb begin
    next_state = state;
    done_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state)
      IDLE:     if (start && !done && !timeout) next_state = STREAM;
      STREAM:   if (accept && (sent == LAST_M1)) next_state = WAIT_FIN;
      WAIT_FIN: begin
        if (load_finish) begin
          next_state = IDLE;
          done_d     = 1'b1;
        end else if (timer == TMO_LAST) begin
          next_state = IDLE;
          timeout_d  = 1'b1;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  // Issue/accept counters and the one-deep read-in-flight tracker, cleared in idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issued       <= '0;
      sent         <= '0;
      inflight     <= 1'b0;
      inflight_fst <= 1'b0;
    end else if (state == IDLE) begin
      issued       <= '0;
      sent         <= '0;
      inflight     <= 1'b0;
      inflight_fst <= 1'b0;
    end else begin
      inflight     <= mem_rd_en;
      inflight_fst <= mem_rd_en && (issued == '0);
      if (mem_rd_en) issued <= issued + 1'b1;
      if (accept)    sent   <= sent + 1'b1;
    end
  end

  // load_finish wait timer, running only in WAIT_FIN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (state != WAIT_FIN) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_tap_stream_tx.sv
// Directed bench for tap_stream_tx: a queue of expected words per load is checked on
// every accept, plus cycle-exact literal expectations for latency, stalls and pulses.
module tb_tap_stream_tx;
  import tap_stream_tx_pkg::*;

  localparam int N = 144;

  logic       clk = 1'b0;
  logic       reset, start, rdy, lf;
  logic       mem_rd_en;
  logic [7:0] mem_rd_addr;
  float_24_8  mem_rd_data;
  float_24_8  tap_in;
  logic       tap_in_fst, tap_in_vld, busy, done, timeout;

  logic       start1, rdy1, lf1;
  logic       m1_en;
  logic [0:0] m1_addr;
  float_24_8  m1_data;
  float_24_8  tap1;
  logic       fst1, vld1, busy1, done1, tmo1;

  logic [31:0] store [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_q [$];
  logic [31:0] e_word;
  int          idx = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [31:0] last_word = '0;
  logic        hold = 1'b0;
  logic [31:0] hold_data = '0;
  logic        hold_fst = 1'b0;
  int          done_cnt = 0;
  int          tmo_cnt = 0;

  tap_stream_tx #(.NUM_TAPS(N), .AW(8), .FIN_TIMEOUT(1023)) dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .tap_in(tap_in), .tap_in_fst(tap_in_fst), .tap_in_vld(tap_in_vld),
    .tap_in_rdy(rdy), .load_finish(lf), .busy(busy), .done(done), .timeout(timeout)
  );

  tap_stream_tx #(.NUM_TAPS(1), .AW(1), .FIN_TIMEOUT(1023)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .mem_rd_en(m1_en), .mem_rd_addr(m1_addr), .mem_rd_data(m1_data),
    .tap_in(tap1), .tap_in_fst(fst1), .tap_in_vld(vld1),
    .tap_in_rdy(rdy1), .load_finish(lf1), .busy(busy1), .done(done1), .timeout(tmo1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous tap stores: data is valid the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= store[mem_rd_addr];
    if (m1_en) m1_data <= (m1_addr == 1'b0) ? 32'hC0A00000 : 32'hFFFFFFFF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every accepted word against the expected queue, and the
  // held word must stay put while the stage is not ready.
  always @(negedge clk) begin
    if (!reset) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_vld", 32'(tap_in_vld), 32'd1);
        check("hold_data", tap_in, hold_data);
        check("hold_fst", 32'(tap_in_fst), 32'(hold_fst));
      end
      if (tap_in_vld) check("vld_implies_busy", 32'(busy), 32'd1);
      if (tap_in_vld && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %h expected no word (cycle %0d)", tap_in, cyc);
        end else begin
          e_word = exp_q.pop_front();
          check("word", tap_in, e_word);
          check("word_fst", 32'(tap_in_fst), 32'(idx == 0));
          if (idx == 0) first_cyc = cyc;
          last_cyc  = cyc;
          last_word = tap_in;
          idx++;
        end
      end
      hold      = tap_in_vld && !rdy;
      hold_data = tap_in;
      hold_fst  = tap_in_fst;
      if (done) done_cnt++;
      if (timeout) tmo_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(store[i]);
    idx = 0;
  endtask

  task automatic pulse_start(output int c);
    start = 1'b1;
    c = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_finish();
    lf = 1'b1;
    tick();
    lf = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int t0, k, lastc, d0;
    for (int i = 0; i < 256; i++) store[i] = 32'h3F800000 + i;
    reset = 1'b0; start = 1'b0; rdy = 1'b0; lf = 1'b0;
    start1 = 1'b0; rdy1 = 1'b1; lf1 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_addr", 32'(mem_rd_addr), 32'd0);
    check("rst_tap", tap_in, 32'd0);
    check("rst_fst", 32'(tap_in_fst), 32'd0);
    check("rst_vld", 32'(tap_in_vld), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Full-rate load with literal latency pins.
    rdy = 1'b1;
    begin_load();
    pulse_start(t0);
    @(negedge clk);
    check("c1_rd_en", 32'(mem_rd_en), 32'd1);
    check("c1_addr", 32'(mem_rd_addr), 32'd0);
    check("c1_vld", 32'(tap_in_vld), 32'd0);
    check("c1_busy", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    check("c2_vld", 32'(tap_in_vld), 32'd1);
    check("c2_fst", 32'(tap_in_fst), 32'd1);
    check("c2_tap", tap_in, 32'h3F800000);
    tick();
    while (cyc < t0 + N + 1) tick();
    pulse_finish();
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check("t1_first_cyc", 32'(first_cyc - t0), 32'd2);
    check("t1_last_cyc", 32'(last_cyc - t0), 32'(N + 1));
    check("t1_last_word", last_word, 32'h3F80008F);
    @(negedge clk);
    check("lf_at_last_ignored", 32'(done), 32'd0);
    check("wait_fin_busy", 32'(busy), 32'd1);
    tick();
    pulse_finish();
    start = 1'b1;
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_on_done_busy", 32'(busy), 32'd0);
    check("start_on_done_rd", 32'(mem_rd_en), 32'd0);
    check("done_single", 32'(done), 32'd0);
    tick();
    check("t1_done_count", 32'(done_cnt), 32'd1);
    pulse_finish();
    @(negedge clk);
    check("lf_idle_ignored", 32'(done), 32'd0);
    tick();

    // Five-cycle stall with a read in flight costs exactly five cycles.
    begin_load();
    pulse_start(t0);
    k = 0;
    while (exp_q.size() != 0 && k < 600) begin
      rdy = !(cyc >= t0 + 40 && cyc < t0 + 45);
      tick();
      k++;
    end
    rdy = 1'b1;
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check("t2_last_cyc", 32'(last_cyc - t0), 32'(N + 1 + 5));
    d0 = done_cnt;
    pulse_finish();
    tick();
    check("t2_done", 32'(done_cnt - d0), 32'd1);

    // Alternating ready plus a second start mid-stream.
    begin_load();
    pulse_start(t0);
    k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      rdy   = ((cyc % 2) == 0);
      start = (cyc == t0 + 30);
      tick();
      k++;
    end
    start = 1'b0;
    rdy = 1'b1;
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check("t3_words", 32'(idx), 32'(N));
    repeat (3) tick();
    d0 = done_cnt;
    pulse_finish();
    repeat (3) tick();
    check("t3_one_done", 32'(done_cnt - d0), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);

    // No load_finish: timeout 1023 cycles after WAIT_FIN is entered.
    begin_load();
    pulse_start(t0);
    k = 0;
    while (exp_q.size() != 0 && k < 600) begin
      tick();
      k++;
    end
    lastc = last_cyc;
    k = 0;
    d0 = done_cnt;
    while (k < 1100) begin
      @(negedge clk);
      if (timeout) break;
      k++;
    end
    check("tmo_seen", 32'(timeout), 32'd1);
    check("tmo_cycle", 32'(cyc - (lastc + 1)), 32'd1023);
    check("tmo_idle", 32'(busy), 32'd0);
    tick();
    @(negedge clk);
    check("tmo_single", 32'(timeout), 32'd0);
    check("tmo_no_done", 32'(done_cnt - d0), 32'd0);
    check("tmo_count", 32'(tmo_cnt), 32'd1);
    tick();

    // Reset mid-load at word 70, then a clean restart from address 0.
    begin_load();
    pulse_start(t0);
    k = 0;
    while (idx < 70 && k < 300) begin
      tick();
      k++;
    end
    check("t5_reached_70", 32'(idx), 32'd70);
    #3;
    reset = 1'b0;
    #1;
    check("arst_rd_en", 32'(mem_rd_en), 32'd0);
    check("arst_addr", 32'(mem_rd_addr), 32'd0);
    check("arst_tap", tap_in, 32'd0);
    check("arst_fst", 32'(tap_in_fst), 32'd0);
    check("arst_vld", 32'(tap_in_vld), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    idx = 0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    begin_load();
    pulse_start(t0);
    k = 0;
    while (exp_q.size() != 0 && k < 600) begin
      tick();
      k++;
    end
    check("t5_drained", 32'(exp_q.size()), 32'd0);
    check("t5_first_cyc", 32'(first_cyc - t0), 32'd2);
    d0 = done_cnt;
    pulse_finish();
    tick();
    check("t5_done", 32'(done_cnt - d0), 32'd1);

    // NUM_TAPS=1 build: one word with fst, then WAIT_FIN.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    @(negedge clk);
    check("n1_rd_en", 32'(m1_en), 32'd1);
    check("n1_addr", 32'(m1_addr), 32'd0);
    tick();
    @(negedge clk);
    check("n1_vld", 32'(vld1), 32'd1);
    check("n1_fst", 32'(fst1), 32'd1);
    check("n1_tap", tap1, 32'hC0A00000);
    tick();
    @(negedge clk);
    check("n1_vld_after", 32'(vld1), 32'd0);
    check("n1_wait_busy", 32'(busy1), 32'd1);
    check("n1_no_reread", 32'(m1_en), 32'd0);
    tick();
    lf1 = 1'b1;
    tick();
    lf1 = 1'b0;
    @(negedge clk);
    check("n1_done", 32'(done1), 32'd1);
    check("n1_idle", 32'(busy1), 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
